// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall/flush, E-stage forwarding,
// mul/div hold and data-memory freeze. Optional perf counters under HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MdStartE,
  input  logic              MemReqM,
  input  logic              DmemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MdBusyE,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushCount
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  state_e     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  // Set on the cycle the finished op leaves E, so its still-asserted MdStartE is not restarted.
  logic       md_done_q, md_done_d;
  logic       freeze, lw_stall, md_start;

  assign freeze   = MemReqM & ~DmemReadyM;
  assign lw_stall = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign md_start = (state_q == StRun) & MdStartE & ~md_done_q & ~freeze;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs)) return 2'b10;
    if (RegWriteW && (RdW != '0) && (RdW == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      md_cnt_q  <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      md_done_q <= md_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    md_done_d = md_done_q;
    if (!freeze) begin
      unique case (state_q)
        StRun: begin
          md_done_d = 1'b0;
          if (md_start) begin
            state_d  = StMdBusy;
            md_cnt_d = 4'(MDU_LAT - 1);
          end
        end
        StMdBusy: begin
          md_cnt_d = md_cnt_q - 4'd1;
          if (md_cnt_q == 4'd1) begin
            state_d   = StRun;
            md_done_d = 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    MdBusyE   = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if (freeze) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        FlushW  = 1'b1;
        MdBusyE = (state_q == StMdBusy);
      end else begin
        unique case (state_q)
          StRun: begin
            if (md_start) begin
              StallF  = 1'b1;
              StallD  = 1'b1;
              StallE  = 1'b1;
              FlushM  = 1'b1;
              MdBusyE = 1'b1;
            end else begin
              StallF = lw_stall & ~PCSrcE;
              StallD = lw_stall & ~PCSrcE;
              FlushD = PCSrcE;
              FlushE = PCSrcE | lw_stall;
            end
          end
          StMdBusy: begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            FlushM  = 1'b1;
            MdBusyE = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  // Saturating counters; clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else if (perf_clr) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (FlushD && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign StallCycles     = '0;
  assign FlushCount      = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed cases followed by random traffic
// checked against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MDU_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE, MemReqM, DmemReadyM, perf_clr;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdBusyE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCycles, FlushCount;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state: remaining busy cycles after the current one, and whether the
  // op that just finished is still sitting in E for its final (non-stalled) cycle.
  int          busy_left;
  bit          rel;
  logic [31:0] m_stall, m_flush;
  logic        last_se;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .MdStartE(MdStartE), .MemReqM(MemReqM), .DmemReadyM(DmemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MdBusyE(MdBusyE),
    .perf_clr(perf_clr), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE, MemReqM, perf_clr} = '0;
    DmemReadyM = 1'b1;
  endtask

  task automatic model_reset();
    busy_left = 0;
    rel       = 1'b0;
    m_stall   = '0;
    m_flush   = '0;
  endtask

  // One clock: inputs are already driven just after a negedge; check, then advance.
  task automatic cyc();
    logic fz, lw, st, sf, sd, se, sm, fd, fe, fm, fw, bz;
    #1;
    fz = MemReqM & ~DmemReadyM;
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    {st, sf, sd, se, sm, fd, fe, fm, fw, bz} = '0;
    if (fz) begin
      {sf, sd, se, sm, fw} = '1;
      bz = (busy_left > 0);
    end else if (busy_left > 0 || (MdStartE && !rel)) begin
      st = (busy_left == 0);
      {sf, sd, se, fm, bz} = '1;
    end else begin
      sf = lw & ~PCSrcE;
      sd = sf;
      fd = PCSrcE;
      fe = PCSrcE | lw;
    end
    last_se = StallE;
    chk("StallF", 32'(StallF), 32'(sf));
    chk("StallD", 32'(StallD), 32'(sd));
    chk("StallE", 32'(StallE), 32'(se));
    chk("StallM", 32'(StallM), 32'(sm));
    chk("FlushD", 32'(FlushD), 32'(fd));
    chk("FlushE", 32'(FlushE), 32'(fe));
    chk("FlushM", 32'(FlushM), 32'(fm));
    chk("FlushW", 32'(FlushW), 32'(fw));
    chk("MdBusyE", 32'(MdBusyE), 32'(bz));
    chk("ForwardAE", 32'(ForwardAE), 32'(fwd(Rs1E)));
    chk("ForwardBE", 32'(ForwardBE), 32'(fwd(Rs2E)));
    chk("StallCycles", StallCycles, m_stall);
    chk("FlushCount", FlushCount, m_flush);
    @(posedge clk);
    if (!fz) begin
      if (busy_left > 0) begin
        busy_left--;
        rel = (busy_left == 0);
      end else begin
        rel = 1'b0;
        if (st) busy_left = MDU_LAT - 1;
      end
    end
`ifdef HAZ_PERF_CNT_EN
    if (perf_clr) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (sf && m_stall != '1) m_stall++;
      if (fd && m_flush != '1) m_flush++;
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    int n;
    idle();
    model_reset();
    reset = 1'b1;
    RdM = 5; RegWriteM = 1; Rs1E = 5; LoadE = 1; RdE = 7; Rs2D = 7;
    #2;
    chk("rst_outs", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                         MdBusyE, ForwardAE, ForwardBE}), 32'd0);
    chk("rst_cnt", StallCycles | FlushCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Forwarding priority and x0 suppression
    RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    cyc();
    chk("t1_fwd_m", 32'(ForwardAE), 32'd2);
    RdM = 0;
    cyc();
    chk("t1_fwd_w", 32'(ForwardAE), 32'd1);

    // Load-use stall, then RdE=0 gives no stall
    idle(); LoadE = 1; RdE = 7; Rs2D = 7;
    cyc();
    chk("t2_lw_stall", 32'({StallF, StallD, FlushE}), 32'b111);
    RdE = 0; Rs2D = 0;
    cyc();
    chk("t2_x0_nostall", 32'({StallF, StallD, FlushE}), 32'b000);

    // Taken branch overrides load-use stall
    idle(); PCSrcE = 1; LoadE = 1; RdE = 3; Rs1D = 3;
    cyc();
    chk("t3_branch", 32'({FlushD, FlushE, StallF}), 32'b110);

    // Mul/div occupies E for MDU_LAT cycles
    idle(); MdStartE = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!last_se) break;
      n++;
    end
    chk("t4_md_len", 32'(n), 32'(MDU_LAT));
    MdStartE = 0;
    cyc();

    // Freeze for 3 cycles at md_cnt=2 delays completion by 3
    MdStartE = 1;
    n = 0;
    cyc(); n += int'(last_se);
    cyc(); n += int'(last_se);
    MemReqM = 1; DmemReadyM = 0;
    repeat (3) begin
      cyc(); n += int'(last_se);
      chk("t5_freeze", 32'({StallM, FlushW, MdBusyE}), 32'b111);
    end
    MemReqM = 0; DmemReadyM = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!last_se) break;
      n++;
    end
    chk("t5_md_len", 32'(n), 32'(MDU_LAT + 3));
    MdStartE = 0;
    cyc();

    // Reset mid-op discards the op
    MdStartE = 1;
    cyc(); cyc();
    reset = 1'b1;
    #2;
    chk("t6_rst_outs", 32'({StallF, StallD, StallE, FlushM, MdBusyE}), 32'd0);
    chk("t6_rst_cnt", StallCycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    MdStartE = 0;
    cyc();
    chk("t6_run", 32'({MdBusyE, StallE}), 32'd0);

    // Build some counts, then clear them
    LoadE = 1; RdE = 2; Rs1D = 2;
    cyc(); cyc();
    idle(); PCSrcE = 1;
    cyc();
    idle(); perf_clr = 1;
    cyc();
    perf_clr = 0;
    cyc();
    chk("t6_clr", StallCycles, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      LoadE  = ($urandom_range(0, 3) == 0);
      PCSrcE = ($urandom_range(0, 4) == 0);
      MdStartE = !LoadE && !PCSrcE && ($urandom_range(0, 4) == 0);
      MemReqM = ($urandom_range(0, 2) == 0);
      DmemReadyM = 1'($urandom);
      perf_clr = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
